// File: rtl/multiplier_datapath_taint_track_word.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multiplier_datapath_taint_track_word                                       |
// | Shift-add multiplier datapath (MD/MR/RS) with sticky word-level taint.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multiplier_datapath_taint_track_word #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     multiplicand_in,
   input  logic                 multiplicand_in_t,
   input  logic [WIDTH-1:0]     multiplier_in,
   input  logic                 multiplier_in_t,
   input  logic                 mdld,
   input  logic                 mdld_t,
   input  logic                 mrld,
   input  logic                 mrld_t,
   input  logic                 rsclear,
   input  logic                 rsclear_t,
   input  logic                 rsload,
   input  logic                 rsload_t,
   input  logic                 rsshr,
   input  logic                 rsshr_t,
   input  logic                 productDone,
   input  logic                 productDone_t,
   output logic [WIDTH-1:0]     multiplierReg,
   output logic                 multiplierReg_t,
   output logic [2*WIDTH-1:0]   product,
   output logic                 product_t,
   output logic                 product_valid,
   output logic                 product_valid_t
);

   logic [WIDTH-1:0]   r_md;
   logic               r_md_t;
   logic [WIDTH-1:0]   r_mr;
   logic               r_mr_t;
   logic [2*WIDTH:0]   r_rs;
   logic               r_rs_t;
   logic               r_valid;
   logic               r_valid_t;

   logic [WIDTH:0]     w_sum;
   logic               w_ctrl_t;

   // Upper half plus carry bit; sum of two WIDTH-bit values always fits.
   assign w_sum    = {1'b0, r_rs[2*WIDTH-1:WIDTH]} + {1'b0, r_md};
   assign w_ctrl_t = rsclear_t | rsload_t | rsshr_t;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_md      <= '0;
         r_md_t    <= 1'b0;
         r_mr      <= '0;
         r_mr_t    <= 1'b0;
         r_rs      <= '0;
         r_rs_t    <= 1'b0;
         r_valid   <= 1'b0;
         r_valid_t <= 1'b0;
      end else begin
         if (mdld) begin
            r_md   <= multiplicand_in;
            r_md_t <= multiplicand_in_t | mdld_t;
         end else begin
            r_md_t <= r_md_t | mdld_t;
         end

         if (mrld) begin
            r_mr   <= multiplier_in;
            r_mr_t <= multiplier_in_t | mrld_t;
         end else begin
            r_mr_t <= r_mr_t | mrld_t;
         end

         if (rsclear) begin
            r_rs   <= '0;
            r_rs_t <= w_ctrl_t;
         end else if (rsload) begin
            r_rs[2*WIDTH:WIDTH] <= w_sum;
            r_rs_t              <= r_rs_t | r_md_t | w_ctrl_t;
         end else if (rsshr) begin
            r_rs   <= {1'b0, r_rs[2*WIDTH:1]};
            r_rs_t <= r_rs_t | w_ctrl_t;
         end else begin
            r_rs_t <= r_rs_t | w_ctrl_t;
         end

         r_valid   <= productDone;
         r_valid_t <= productDone_t;
      end
   end

   assign multiplierReg   = r_mr;
   assign multiplierReg_t = r_mr_t;
   assign product         = r_rs[2*WIDTH-1:0];
   assign product_t       = r_rs_t;
   assign product_valid   = r_valid;
   assign product_valid_t = r_valid_t;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_datapath_taint_track_word.sv
`default_nettype none
// Directed bench for multiplier_datapath_taint_track_word: vector table of
// full multiplies plus hand sequences for taint, priority and reset corners.
module tb_multiplier_datapath_taint_track_word;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [W-1:0] multiplicand_in = '0, multiplier_in = '0;
   logic multiplicand_in_t = 0, multiplier_in_t = 0;
   logic mdld = 0, mdld_t = 0, mrld = 0, mrld_t = 0;
   logic rsclear = 0, rsclear_t = 0, rsload = 0, rsload_t = 0;
   logic rsshr = 0, rsshr_t = 0, productDone = 0, productDone_t = 0;
   logic [W-1:0]   multiplierReg;
   logic           multiplierReg_t;
   logic [2*W-1:0] product;
   logic           product_t, product_valid, product_valid_t;

   int checks = 0;
   int errors = 0;

   multiplier_datapath_taint_track_word #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .multiplicand_in(multiplicand_in), .multiplicand_in_t(multiplicand_in_t),
      .multiplier_in(multiplier_in), .multiplier_in_t(multiplier_in_t),
      .mdld(mdld), .mdld_t(mdld_t), .mrld(mrld), .mrld_t(mrld_t),
      .rsclear(rsclear), .rsclear_t(rsclear_t),
      .rsload(rsload), .rsload_t(rsload_t),
      .rsshr(rsshr), .rsshr_t(rsshr_t),
      .productDone(productDone), .productDone_t(productDone_t),
      .multiplierReg(multiplierReg), .multiplierReg_t(multiplierReg_t),
      .product(product), .product_t(product_t),
      .product_valid(product_valid), .product_valid_t(product_valid_t)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   md;
      logic [W-1:0]   mr;
      logic           md_t;
      logic [2*W-1:0] prod;
      logic           prod_t;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mdld = 0; mdld_t = 0; mrld = 0; mrld_t = 0;
      rsclear = 0; rsclear_t = 0; rsload = 0; rsload_t = 0;
      rsshr = 0; rsshr_t = 0; productDone = 0; productDone_t = 0;
      multiplicand_in_t = 0; multiplier_in_t = 0;
   endtask

   task automatic load_ops(input logic [W-1:0] md, input logic [W-1:0] mr, input logic md_t);
      idle();
      mdld = 1; mrld = 1;
      multiplicand_in = md; multiplier_in = mr; multiplicand_in_t = md_t;
      cycle();
      idle();
   endtask

   task automatic do_mul(input logic [W-1:0] md, input logic [W-1:0] mr, input logic md_t);
      load_ops(md, mr, md_t);
      rsclear = 1;
      cycle();
      idle();
      for (int i = 0; i < W; i++) begin
         if (mr[i]) begin
            rsload = 1;
            cycle();
            idle();
         end
         rsshr = 1;
         productDone = (i == W - 1);
         cycle();
         idle();
      end
   endtask

   initial begin
      vecs[0] = '{4'd3,  4'd5,  1'b0, 8'd15,  1'b0};
      vecs[1] = '{4'd15, 4'd15, 1'b0, 8'd225, 1'b0};
      vecs[2] = '{4'd3,  4'd5,  1'b1, 8'd15,  1'b1};
      vecs[3] = '{4'd7,  4'd0,  1'b1, 8'd0,   1'b0};
      vecs[4] = '{4'd0,  4'd9,  1'b0, 8'd0,   1'b0};
      vecs[5] = '{4'd9,  4'd1,  1'b0, 8'd9,   1'b0};
      vecs[6] = '{4'd1,  4'd15, 1'b1, 8'd15,  1'b1};
      vecs[7] = '{4'd12, 4'd10, 1'b0, 8'd120, 1'b0};

      // Reset with every strobe and taint high.
      mdld = 1; mdld_t = 1; mrld = 1; mrld_t = 1;
      rsclear = 1; rsclear_t = 1; rsload = 1; rsload_t = 1;
      rsshr = 1; rsshr_t = 1; productDone = 1; productDone_t = 1;
      multiplicand_in = 4'hF; multiplier_in = 4'hF;
      multiplicand_in_t = 1; multiplier_in_t = 1;
      rst = 0;
      cycle();
      cycle();
      chk("rst_mr",      32'(multiplierReg),   32'd0);
      chk("rst_mr_t",    32'(multiplierReg_t), 32'd0);
      chk("rst_prod",    32'(product),         32'd0);
      chk("rst_prod_t",  32'(product_t),       32'd0);
      chk("rst_valid",   32'(product_valid),   32'd0);
      chk("rst_valid_t", 32'(product_valid_t), 32'd0);
      idle();
      rst = 1;
      cycle();

      for (int v = 0; v < 8; v++) begin
         do_mul(vecs[v].md, vecs[v].mr, vecs[v].md_t);
         chk("vec_prod",   32'(product),         32'(vecs[v].prod));
         chk("vec_prod_t", 32'(product_t),       32'(vecs[v].prod_t));
         chk("vec_valid",  32'(product_valid),   32'd1);
         chk("vec_mr",     32'(multiplierReg),   32'(vecs[v].mr));
         chk("vec_mr_t",   32'(multiplierReg_t), 32'd0);
         cycle();
         chk("vec_valid_drop", 32'(product_valid), 32'd0);
      end

      // Operand taint appears right after the first rsload.
      load_ops(4'd3, 4'd5, 1'b1);
      rsclear = 1; cycle(); idle();
      chk("opt_before_load", 32'(product_t), 32'd0);
      rsload = 1; cycle(); idle();
      chk("opt_after_load", 32'(product_t), 32'd1);
      chk("opt_load_val",   32'(product),   32'h30);

      // Control taint without firing.
      do_mul(4'd3, 4'd5, 1'b0);
      rsshr_t = 1; cycle(); idle();
      chk("ct_rs_val",   32'(product),   32'd15);
      chk("ct_rs_t",     32'(product_t), 32'd1);
      cycle();
      chk("ct_rs_t_sticky", 32'(product_t), 32'd1);
      mrld_t = 1; cycle(); idle();
      chk("ct_mr_val", 32'(multiplierReg),   32'd5);
      chk("ct_mr_t",   32'(multiplierReg_t), 32'd1);
      cycle();
      chk("ct_mr_t_sticky", 32'(multiplierReg_t), 32'd1);
      rsclear = 1; cycle(); idle();
      chk("ct_clear_val", 32'(product),   32'd0);
      chk("ct_clear_t",   32'(product_t), 32'd0);
      load_ops(4'd3, 4'd6, 1'b0);
      chk("ct_mrld_clean_t", 32'(multiplierReg_t), 32'd0);
      chk("ct_mrld_val",     32'(multiplierReg),   32'd6);

      // Tainted clear leaves RS tainted.
      rsclear = 1; rsclear_t = 1; cycle(); idle();
      chk("tclear_t", 32'(product_t), 32'd1);

      // Priority: clear beats load and shift; load beats shift.
      do_mul(4'd3, 4'd5, 1'b0);
      rsclear = 1; rsload = 1; rsshr = 1; cycle(); idle();
      chk("prio_clear", 32'(product), 32'd0);
      rsload = 1; rsshr = 1; cycle(); idle();
      chk("prio_load", 32'(product), 32'h30);

      // rsload alongside mdld adds the old multiplicand.
      rsclear = 1; cycle(); idle();
      mdld = 1; multiplicand_in = 4'd9; rsload = 1; cycle(); idle();
      chk("old_md_add", 32'(product), 32'h30);
      rsload = 1; cycle(); idle();
      chk("new_md_add", 32'(product), 32'hC0);

      // Taint on productDone alone.
      productDone_t = 1; cycle(); idle();
      chk("pd_t_valid",   32'(product_valid),   32'd0);
      chk("pd_t_valid_t", 32'(product_valid_t), 32'd1);

      // Reset mid-multiply.
      load_ops(4'd3, 4'd5, 1'b0);
      rsclear = 1; cycle(); idle();
      rsload = 1; cycle(); idle();
      chk("mid_pre_rst", 32'(product), 32'h30);
      rst = 0; rsshr = 1; cycle(); idle();
      rst = 1;
      chk("mid_rst_prod", 32'(product),       32'd0);
      chk("mid_rst_mr",   32'(multiplierReg), 32'd0);
      do_mul(4'd3, 4'd5, 1'b0);
      chk("mid_rst_remul",   32'(product),       32'd15);
      chk("mid_rst_valid",   32'(product_valid), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/multiplier_datapath_taint_track_word.md
# multiplier_datapath_taint_track_word

Datapath stage of the sequential shift-add multiplier with word-level taint tracking. It holds the multiplicand, the multiplier and the running-sum/product registers, and executes the load, clear, add and shift strobes issued by the multiplier control FSM. It returns the multiplier word and its taint bit to the controller. It exposes the product with a one-bit word taint and a valid pulse.

## Interface
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low: 0 resets on the rising edge of clk.
- multiplicand_in  input  WIDTH  multiplicand operand; taint multiplicand_in_t (1).
- multiplier_in  input  WIDTH  multiplier operand; taint multiplier_in_t (1).
- mdld / mdld_t  input  1 / 1  load multiplicand register; taint of strobe.
- mrld / mrld_t  input  1 / 1  load multiplier register; taint of strobe.
- rsclear / rsclear_t  input  1 / 1  clear running sum; taint.
- rsload / rsload_t  input  1 / 1  add multiplicand into upper half of running sum; taint.
- rsshr / rsshr_t  input  1 / 1  shift running sum right by one; taint.
- productDone / productDone_t  input  1 / 1  final-cycle indication from control; taint.
- multiplierReg  output  WIDTH  multiplier register contents, to control.
- multiplierReg_t  output  1  word taint of multiplierReg.
- product  output  2*WIDTH  RS[2*WIDTH-1:0].
- product_t  output  1  word taint of running sum.
- product_valid / product_valid_t  output  1 / 1  registered productDone; taint.

## Operation
- Registers:
  - MD holds the multiplicand (WIDTH bits).
  - MR holds the multiplier (WIDTH bits).
  - RS holds the running sum (2*WIDTH+1 bits; bit 2*WIDTH is the carry).
  - Each register carries a 1-bit taint: MD_t, MR_t, RS_t.
- MD: if mdld, MD <= multiplicand_in; else hold.
- MR: if mrld, MR <= multiplier_in; else hold.
- MR is never shifted. Control indexes it by bit position.
- RS operations, with priority rsclear > rsload > rsshr:
  - rsclear: RS <= 0.
  - rsload: RS[2W:W] <= {1'b0, RS[2W-1:W]} + {1'b0, MD}. RS[W-1:0] holds.
  - rsshr: RS <= RS >> 1, with a zero shifted into bit 2W.
  - none asserted: hold.
- Simultaneous strobes resolve by priority only. No combined add-and-shift.
- MD/MR taint:
  - load asserted: reg_t <= in_t | ld_t.
  - load not asserted: reg_t <= reg_t | ld_t.
  - A tainted strobe taints the word whether or not it fires.
- RS taint: let ctrl_t = rsclear_t | rsload_t | rsshr_t.
  - rsclear: RS_t <= ctrl_t.
  - rsload: RS_t <= RS_t | MD_t | ctrl_t.
  - rsshr or hold: RS_t <= RS_t | ctrl_t.
- Taint is sticky. It is cleared only by reset, or by an untainted clear/load of that register.
- product_valid <= productDone; product_valid_t <= productDone_t.
- Outputs multiplierReg, multiplierReg_t, product and product_t are direct register outputs, not combinational from inputs.

## Timing
- Reset (rst=0 at an edge) sets every register and every taint to 0.
  - Outputs become: multiplierReg=0, multiplierReg_t=0, product=0, product_t=0, product_valid=0, product_valid_t=0.
- Reset overrides all strobes in the same cycle.
- Reset mid-multiplication discards the partial RS and the operands.
- All strobes take effect at the edge on which they are sampled high. Results are visible the following cycle.
- Latency is 1 cycle from strobe to register update.
- The controller's FINAL state asserts rsshr and productDone together. The final shift and product_valid therefore appear in the same cycle, so product is final when product_valid=1.
- Wrap-around: the rsload carry goes into RS[2W]. The carry is never lost for WIDTH-bit operands. The sum never exceeds 2^(W+1)-1.
- mdld/mrld concurrent with RS strobes are independent. rsload in the same cycle as mdld uses the old MD.

## Test plan
- Reset and taint clear:
  - Stimulus: hold rst=0 for 2 cycles with all strobes and taints high.
  - Response: all outputs 0.
- Clean multiply, WIDTH=4:
  - Stimulus: mdld/mrld with 3 and 5, rsclear, then per bit i: rsload if MR[i], then rsshr. The last rsshr comes with productDone.
  - Response: product=15, product_t=0, product_valid=1 one cycle later.
- Carry path:
  - Stimulus: 15×15 with the same sequence.
  - Response: product=225 (0xE1), no truncation.
- Operand taint:
  - Stimulus: multiplicand_in_t=1 at mdld, then the 3×5 sequence.
  - Response: multiplierReg_t=0; product_t becomes 1 after the first rsload and stays 1; product=15.
- Control taint without firing:
  - Stimulus: rsshr=0 with rsshr_t=1 for one cycle; separately mrld=0 with mrld_t=1.
  - Response: RS value unchanged but product_t=1. MR unchanged but multiplierReg_t=1. Both stay 1 until rsclear/mrld with clean taint.
- Priority and reset mid-op:
  - Stimulus: rsclear, rsload and rsshr together.
  - Response: RS=0.
  - Stimulus: rst=0 after 3 strobes of a multiply.
  - Response: product=0; a following full 3×5 yields 15.
